mul_unit: RTL and testbench

MUL_UNIT -- requirements
Module: mul_unit

---
 rtl/mul_unit_pkg.sv | 30 +++
 rtl/ripple_adder.sv | 22 ++
 rtl/mul_unit.sv | 124 ++++++++++++
 tb/tb_mul_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_unit_pkg.sv
// Shared multiply encodings: op codes (RV32M funct3[1:0]), FSM states, iteration count.
// Imported by decode, execute and the iterative multiplier.
package mul_unit_pkg;

  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Returns {rs1_is_signed, rs2_is_signed}.
  function automatic logic [1:0] op_signs(op_e o);
    case (o)
      OP_MUL, OP_MULH: return 2'b11;
      OP_MULHSU:       return 2'b10;
      default:         return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ripple_adder.sv
// Combinational W-bit adder from a chain of full-adder cells, carry-in tied to 0.
// Zero latency; carry-out is dropped since the accumulator never overflows its width.
module ripple_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W-1:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ carry[i];
    if (i < W - 1) begin : g_cout
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU; done pulses 32 cycles
// after accept, busy covers RUN+DONE, start is ignored while busy and kill aborts at any time.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int PW = 2 * XLEN;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [XLEN-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             neg_q, neg_d;
  op_e              op_q, op_d;

  logic [1:0]       sgn;
  logic             rs1_neg, rs2_neg;
  logic [XLEN-1:0]  rs1_mag, rs2_mag;
  logic [PW-1:0]    addend, sum, prod;
  logic             last;

  // Magnitudes are taken as unsigned XLEN values, so the most negative input maps to 2^(XLEN-1).
  assign sgn     = op_signs(op_e'(op));
  assign rs1_neg = sgn[1] & rs1[XLEN-1];
  assign rs2_neg = sgn[0] & rs2[XLEN-1];
  assign rs1_mag = rs1_neg ? -rs1 : rs1;
  assign rs2_mag = rs2_neg ? -rs2 : rs2;

  assign addend = mplier_q[0] ? mcand_q : '0;

  ripple_adder #(.W(PW)) u_adder (
    .a   (acc_q),
    .b   (addend),
    .sum (sum)
  );

  assign prod = neg_q ? -sum : sum;
  assign last = (cnt_q == CNT_W'(ITERS - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    neg_d    = neg_q;
    op_d     = op_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{XLEN{1'b0}}, rs1_mag};
          mplier_d = rs2_mag;
          neg_d    = rs1_neg ^ rs2_neg;
          op_d     = op_e'(op);
        end
      end
      S_RUN: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (last) begin
          result_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flush wins over everything, including a same-cycle start or completion.
    if (kill) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      op_q     <= OP_MUL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      op_q     <= op_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Bench for mul_unit: directed vector table, kill/reset/held-start sequences, random ops vs reference.
module tb_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        kill;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int nvec = 0;
  int nbad = 0;

  mul_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .kill   (kill),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (actual running, required finished)");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  vop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  // Reference: extend each operand per op signedness, take the full 64-bit product.
  function automatic logic [31:0] ref_mul(logic [1:0] o, logic [31:0] a, logic [31:0] b);
    logic [63:0] x, y, p;
    x = (o != 2'b11) ? {{32{a[31]}}, a} : {32'b0, a};
    y = (o == 2'b00 || o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    p = x * y;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // One operation: start pulse, then wait (bounded) for done; operands are scrambled while running.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int bc, output logic [31:0] res);
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bc = busy ? 1 : 0;
    lat = 0;
    res = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (busy) bc++;
      if (done) begin
        lat = i;
        res = result;
        break;
      end
      rs1 = $urandom; rs2 = $urandom; op = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    check("post_done_busy", {63'b0, busy}, 64'd0);
    check("post_done_done", {63'b0, done}, 64'd0);
  endtask

  int lat, bc, ndone;
  logic [31:0] res, prev;
  int done_at[$];

  initial begin
    rst = 1'b0; start = 1'b0; kill = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy",   {63'b0, busy}, 64'd0);
    check("reset_done",   {63'b0, done}, 64'd0);
    check("reset_result", {32'b0, result}, 64'd0);
    @(negedge clk); rst = 1'b1;

    // Basic latency / busy-width case.
    do_op(2'b00, 32'd3, 32'd5, lat, bc, res);
    check("basic_latency", lat, 32);
    check("basic_result",  {32'b0, res}, 64'h0000000F);
    check("basic_busy_cycles", bc, 33);

    vecs.push_back('{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
    vecs.push_back('{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    vecs.push_back('{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    vecs.push_back('{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    vecs.push_back('{2'b01, 32'h80000000, 32'h80000000, 32'h40000000});
    vecs.push_back('{2'b11, 32'h80000000, 32'h80000000, 32'h40000000});
    vecs.push_back('{2'b00, 32'h80000000, 32'h80000000, 32'h00000000});
    vecs.push_back('{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    vecs.push_back('{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF});
    vecs.push_back('{2'b11, 32'hFFFFFFFE, 32'h00000003, 32'h00000002});
    vecs.push_back('{2'b00, 32'h00000000, 32'h12345678, 32'h00000000});
    vecs.push_back('{2'b11, 32'h00000000, 32'h00000000, 32'h00000000});
    foreach (vecs[i]) begin
      do_op(vecs[i].vop, vecs[i].a, vecs[i].b, lat, bc, res);
      check($sformatf("vec%0d_latency", i), lat, 32);
      check($sformatf("vec%0d_result", i), {32'b0, res}, {32'b0, vecs[i].exp});
    end

    // Kill during the 10th RUN cycle.
    prev = 32'h00000000;  // last table entry produced 0
    do_op(2'b00, 32'd9, 32'd9, lat, bc, res);
    prev = 32'd81;
    check("pre_kill_result", {32'b0, res}, {32'b0, prev});
    @(negedge clk); op = 2'b00; rs1 = 32'd1000; rs2 = 32'd1000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) @(posedge clk);
    #1; kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    check("kill_busy",   {63'b0, busy}, 64'd0);
    check("kill_done",   {63'b0, done}, 64'd0);
    check("kill_result", {32'b0, result}, {32'b0, prev});
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    check("kill_no_done", ndone, 0);
    check("kill_result_held", {32'b0, result}, {32'b0, prev});
    do_op(2'b01, 32'hFFFFFFF0, 32'h7FFFFFFF, lat, bc, res);
    check("after_kill_latency", lat, 32);
    check("after_kill_result", {32'b0, res}, {32'b0, ref_mul(2'b01, 32'hFFFFFFF0, 32'h7FFFFFFF)});

    // Kill beats a simultaneous start in IDLE.
    @(negedge clk); start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; start = 1'b0; kill = 1'b0;
    check("kill_over_start_busy", {63'b0, busy}, 64'd0);

    // Start held high: one op per IDLE entry, done pulses 34 cycles apart.
    @(negedge clk); op = 2'b11; rs1 = 32'hDEADBEEF; rs2 = 32'h12345678; start = 1'b1;
    done_at.delete();
    for (int i = 0; i < 110; i++) begin
      @(posedge clk); #1;
      if (done) begin
        done_at.push_back(i);
        check($sformatf("held_result%0d", done_at.size()), {32'b0, result},
              {32'b0, ref_mul(2'b11, 32'hDEADBEEF, 32'h12345678)});
      end
    end
    start = 1'b0;
    check("held_done_count", done_at.size(), 3);
    if (done_at.size() >= 1) check("held_first_done", done_at[0], 32);
    for (int i = 1; i < done_at.size(); i++)
      check($sformatf("held_gap%0d", i), done_at[i] - done_at[i-1], 34);
    repeat (40) @(posedge clk);

    // Reset during the 5th RUN cycle.
    @(negedge clk); op = 2'b00; rs1 = 32'd123; rs2 = 32'd456; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b0; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1; rst = 1'b1; start = 1'b0; kill = 1'b0;
    check("midrst_busy",   {63'b0, busy}, 64'd0);
    check("midrst_done",   {63'b0, done}, 64'd0);
    check("midrst_result", {32'b0, result}, 64'd0);
    ndone = 0;
    repeat (40) begin @(posedge clk); #1; if (done) ndone++; end
    check("midrst_no_done", ndone, 0);
    do_op(2'b00, 32'd7, 32'd6, lat, bc, res);
    check("after_rst_latency", lat, 32);
    check("after_rst_result", {32'b0, res}, 64'h0000002A);

    // Random operations against the reference.
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (i % 8 == 0) ra = 32'h80000000;
      if (i % 8 == 1) rb = 32'hFFFFFFFF;
      if (i % 8 == 2) ra = 32'h0;
      do_op(ro, ra, rb, lat, bc, res);
      check($sformatf("rand%0d_latency", i), lat, 32);
      check($sformatf("rand%0d_op%0d_%08h_%08h", i, ro, ra, rb), {32'b0, res},
            {32'b0, ref_mul(ro, ra, rb)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
